// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and constants for the shift_reg sequencer.
//   state_t   : controller FSM states
//   DIR_LEFT  : shift toward MSB (din enters at bit 0)
//   DIR_RIGHT : shift toward LSB (din enters at bit WIDTH-1)
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_ctrl.sv
// Sequencer for a serial-in shift register. Accepts a word, direction and
// shift count on a valid/ready command channel, drives the register's
// din/shift_en/dir for exactly that many cycles, then presents the register
// contents on a valid/ready response channel.
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready     : command handshake
//   cmd_data/cmd_dir/cmd_len: word, direction (0 left, 1 right), shift count
//                             (0 or >WIDTH means WIDTH)
//   sr_din/sr_shift_en/sr_dir: drive to shift_reg
//   sr_q                    : shift_reg contents
//   rsp_valid/rsp_ready     : response handshake
//   rsp_q                   : register contents at completion
//   busy                    : high whenever not IDLE
//   abort                   : present only with SHIFT_REG_CTRL_ABORT_EN defined;
//                             cancels an operation in SHIFT or DONE
//
// Build option: `define SHIFT_REG_CTRL_ABORT_EN adds the abort input.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
`ifdef SHIFT_REG_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             sr_din,
  output logic             sr_shift_en,
  output logic             sr_dir,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_q,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] buffer;
  logic [CNT_W-1:0] count;
  logic             dir_q;
  logic [CNT_W-1:0] eff_len;
  logic             abort_c;
  logic             accept;
  logic             shifting;

`ifdef SHIFT_REG_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Zero and out-of-range lengths both mean a full-width shift.
  assign eff_len  = (cmd_len == '0 || cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;
  assign accept   = (state == IDLE) && cmd_valid;
  assign shifting = (state == SHIFT) && !abort_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bit buffer, remaining-shift counter and direction latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      count  <= '0;
      dir_q  <= DIR_LEFT;
    end else if (accept) begin
      buffer <= cmd_data;
      count  <= eff_len;
      dir_q  <= cmd_dir;
    end else if (shifting) begin
      // Move the next bit to be emitted into the emitting end.
      if (dir_q == DIR_LEFT) begin
        buffer <= {buffer[WIDTH-2:0], 1'b0};
      end else begin
        buffer <= {1'b0, buffer[WIDTH-1:1]};
      end
      count <= count - CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_c) begin
          state_nxt = IDLE;
        end else if (count == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready || abort_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready   = 1'b0;
    sr_shift_en = 1'b0;
    sr_din      = 1'b0;
    sr_dir      = 1'b0;
    rsp_valid   = 1'b0;
    rsp_q       = '0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      SHIFT: begin
        sr_shift_en = !abort_c;
        sr_dir      = dir_q;
        sr_din      = (dir_q == DIR_RIGHT) ? buffer[0] : buffer[WIDTH-1];
      end
      DONE: begin
        // Register is frozen here, so a pass-through of sr_q is stable.
        rsp_valid = !abort_c;
        rsp_q     = sr_q;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl with a behavioural shift_reg attached.
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_len = 4'd0;
  logic       abort = 1'b0;
  logic       sr_din;
  logic       sr_shift_en;
  logic       sr_dir;
  logic [7:0] sr_q;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_q;
  logic       busy;

  logic       preload_en = 1'b0;
  logic [7:0] preload_val = 8'h00;
  logic [7:0] env_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .cmd_dir(cmd_dir),
    .cmd_len(cmd_len),
`ifdef SHIFT_REG_CTRL_ABORT_EN
    .abort(abort),
`endif
    .sr_din(sr_din),
    .sr_shift_en(sr_shift_en),
    .sr_dir(sr_dir),
    .sr_q(sr_q),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_q(rsp_q),
    .busy(busy)
  );

  // Attached shift register (not cleared by reset), with a bench preload port.
  always @(posedge clk) begin
    if (preload_en) env_q <= preload_val;
    else if (sr_shift_en) env_q <= sr_dir ? {sr_din, env_q[7:1]} : {env_q[6:0], sr_din};
  end
  assign sr_q = env_q;

  // Reference model: pending serial bits of the current command, then a
  // pending response with the arithmetically computed final register value.
  bit   m_bits[$];
  bit   m_dir;
  bit   m_rsp;
  logic [7:0] m_final;

  // Last sampled outputs, for per-command observation.
  logic       last_en, last_din, last_rv;
  logic [7:0] last_rq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_rsp = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_update();
    int n, q, d;
    if (!rst_n) begin
      model_reset();
    end else if (abort && (m_bits.size() > 0 || m_rsp)) begin
      model_reset();
    end else if (m_bits.size() > 0) begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) m_rsp = 1'b1;
    end else if (m_rsp) begin
      if (rsp_ready) m_rsp = 1'b0;
    end else if (cmd_valid) begin
      n = (cmd_len == 4'd0 || cmd_len > 4'd8) ? 8 : int'(cmd_len);
      for (int i = 0; i < n; i++) m_bits.push_back(cmd_dir ? cmd_data[i] : cmd_data[7-i]);
      m_dir = cmd_dir;
      q = int'(env_q);
      d = int'(cmd_data);
      if (cmd_dir) m_final = 8'(((q >> n) | ((d & ((1 << n) - 1)) << (8 - n))) & 255);
      else         m_final = 8'(((q << n) | (d >> (8 - n))) & 255);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    bit idle, shifting, resp;
    idle     = (m_bits.size() == 0) && !m_rsp;
    shifting = (m_bits.size() > 0) && !abort;
    resp     = m_rsp && !abort;
    chk("cmd_ready", 32'(cmd_ready), 32'(idle));
    chk("busy", 32'(busy), 32'(!idle));
    chk("sr_shift_en", 32'(sr_shift_en), 32'(shifting));
    chk("rsp_valid", 32'(rsp_valid), 32'(resp));
    if (shifting) begin
      chk("sr_din", 32'(sr_din), 32'(m_bits[0]));
      chk("sr_dir", 32'(sr_dir), 32'(m_dir));
    end
    if (resp) chk("rsp_q", 32'(rsp_q), 32'(m_final));
    if (idle) chk("rsp_q_idle", 32'(rsp_q), 32'(0));
    last_en  = sr_shift_en;
    last_din = sr_din;
    last_rv  = rsp_valid;
    last_rq  = rsp_q;
  endtask

  // One clock: check mid-cycle, then model the edge; inputs may change after.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Issue one command and collect what was seen, holding the response for
  // 'hold' extra cycles. With keep set, a follow-up command stays pending.
  task automatic run_cmd(input logic [7:0] d, input logic dir, input logic [3:0] len,
                         input int hold, input bit keep, input logic [7:0] nd,
                         output int acc_t, output int shifts, output logic [7:0] dins,
                         output int rsp_at, output logic [7:0] rq);
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_len = len; rsp_ready = 1'b0;
    acc_t = 0;
    do begin tick(); acc_t++; end while (m_bits.size() == 0 && acc_t < 50);
    if (acc_t >= 50) chk("accept_timeout", 32'(acc_t), 32'(0));
    if (keep) begin cmd_data = nd; cmd_dir = ~dir; cmd_len = 4'd3; end
    else begin cmd_valid = 1'b0; cmd_data = 8'($urandom); end
    shifts = 0; dins = 8'h00; rsp_at = -1; rq = 8'h00;
    for (int k = 1; k <= 40 && rsp_at < 0; k++) begin
      tick();
      if (last_en) begin shifts++; dins = {dins[6:0], last_din}; end
      if (last_rv) begin rsp_at = k; rq = last_rq; end
    end
    if (rsp_at < 0) chk("rsp_timeout", 32'(rsp_at), 32'(0));
    for (int h = 0; h < hold; h++) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int acc_t, shifts, rsp_at;
    logic [7:0] dins, rq;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_shift_en", 32'(sr_shift_en), 32'(0));
    chk("rst_din", 32'(sr_din), 32'(0));
    chk("rst_dir", 32'(sr_dir), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_q", 32'(rsp_q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    preload_en = 1'b1; preload_val = 8'h00;
    tick();
    preload_en = 1'b0;

    // A5 left, len 0 means 8
    run_cmd(8'hA5, 1'b0, 4'd0, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("a5_shifts", 32'(shifts), 32'(8));
    chk("a5_din_seq", 32'(dins), 32'h0000_00A5);
    chk("a5_rsp_cycle", 32'(rsp_at), 32'(9));
    chk("a5_rsp_q", 32'(rq), 32'h0000_00A5);

    // 3C right, len 8: emits bit0 first
    run_cmd(8'h3C, 1'b1, 4'd8, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("3c_din_seq", 32'(dins), 32'h0000_003C);
    chk("3c_rsp_q", 32'(rq), 32'h0000_003C);

    // Preload 00, then F0 left by 4
    preload_en = 1'b1; preload_val = 8'h00;
    tick();
    preload_en = 1'b0;
    run_cmd(8'hF0, 1'b0, 4'd4, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("f0_shifts", 32'(shifts), 32'(4));
    chk("f0_din_seq", 32'(dins), 32'h0000_000F);
    chk("f0_rsp_q", 32'(rq), 32'h0000_000F);

    // Saturating length: 12 acts as 8
    run_cmd(8'h69, 1'b1, 4'd12, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("sat_shifts", 32'(shifts), 32'(8));
    chk("sat_rsp_q", 32'(rq), 32'h0000_0069);

    // Hold the response 5 cycles with a new command pending
    run_cmd(8'h96, 1'b0, 4'd8, 5, 1'b1, 8'h5A, acc_t, shifts, dins, rsp_at, rq);
    chk("hold_rsp_q", 32'(rq), 32'h0000_0096);
    run_cmd(8'h5A, 1'b1, 4'd3, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("next_accept_delay", 32'(acc_t), 32'(1));
    chk("next_shifts", 32'(shifts), 32'(3));
    chk("next_din_seq", 32'(dins), 32'h0000_0002);

    // Reset after 3 of 8 shifts
    cmd_valid = 1'b1; cmd_data = 8'hE7; cmd_dir = 1'b0; cmd_len = 4'd8;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_shift_en", 32'(sr_shift_en), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    run_cmd(8'hC3, 1'b1, 4'd8, 0, 1'b0, 8'h00, acc_t, shifts, dins, rsp_at, rq);
    chk("postrst_rsp_q", 32'(rq), 32'h0000_00C3);
    chk("postrst_rsp_cycle", 32'(rsp_at), 32'(9));

`ifdef SHIFT_REG_CTRL_ABORT_EN
    // Abort during shift 2 of 8
    cmd_valid = 1'b1; cmd_data = 8'hB4; cmd_dir = 1'b0; cmd_len = 4'd8;
    tick();
    cmd_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
`endif

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid   = ($urandom_range(0, 1) == 1);
      cmd_data    = 8'($urandom);
      cmd_dir     = 1'($urandom);
      cmd_len     = 4'($urandom_range(0, 15));
      rsp_ready   = ($urandom_range(0, 2) != 0);
      preload_en  = !cmd_valid && m_bits.size() == 0 && !m_rsp && ($urandom_range(0, 7) == 0);
      preload_val = 8'($urandom);
`ifdef SHIFT_REG_CTRL_ABORT_EN
      abort       = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    cmd_valid = 1'b0; preload_en = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
